// File: rtl/decode_stage.sv
// RV64I decode stage: registers each fetched {pc, instr} and decodes it for execute.
// An output register plus a one-entry skid register give full throughput behind a registered if_ready_o.
module decode_stage #(
    parameter int XLEN = 64,
    parameter int ILEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            if_valid_i,
    output logic            if_ready_o,
    input  logic [XLEN-1:0] if_pc_i,
    input  logic [ILEN-1:0] if_instr_i,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [XLEN-1:0] id_pc_o,
    output logic [4:0]      id_rs1_o,
    output logic [4:0]      id_rs2_o,
    output logic [4:0]      id_rd_o,
    output logic [XLEN-1:0] id_imm_o,
    output logic [3:0]      id_alu_op_o,
    output logic            id_src_imm_o,
    output logic            id_src_pc_o,
    output logic            id_reg_we_o,
    output logic            id_mem_rd_o,
    output logic            id_mem_wr_o,
    output logic            id_branch_o,
    output logic            id_jump_o,
    output logic            id_system_o,
    output logic [2:0]      id_funct3_o,
    output logic            id_illegal_o
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
        ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
        ALU_OR   = 4'd8, ALU_AND = 4'd9
    } alu_op_t;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL   = 7'b1101111,
        OP_JALR   = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
        OP_STORE  = 7'b0100011, OP_IMM   = 7'b0010011, OP_REG   = 7'b0110011,
        OP_SYSTEM = 7'b1110011
    } opcode_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        alu_op_t         alu_op;
        logic            src_imm;
        logic            src_pc;
        logic            reg_we;
        logic            mem_rd;
        logic            mem_wr;
        logic            branch;
        logic            jump;
        logic            system;
        logic [2:0]      funct3;
        logic            illegal;
    } dec_t;

    function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic dec_t decode(input logic [XLEN-1:0] pc, input logic [ILEN-1:0] ins);
        dec_t       d;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       bad;
        d        = '0;
        d.pc     = pc;
        d.rs1    = ins[19:15];
        d.rs2    = ins[24:20];
        d.rd     = ins[11:7];
        d.alu_op = ALU_ADD;
        f3       = ins[14:12];
        f7       = ins[31:25];
        d.funct3 = f3;
        bad      = (ins[1:0] != 2'b11);
        case (ins[6:0])
            OP_LUI: begin
                d.rs1 = '0; d.imm = {{(XLEN-32){ins[31]}}, ins[31:12], 12'b0};
                d.src_imm = 1'b1; d.reg_we = 1'b1;
            end
            OP_AUIPC: begin
                d.rs1 = '0; d.imm = {{(XLEN-32){ins[31]}}, ins[31:12], 12'b0};
                d.src_imm = 1'b1; d.src_pc = 1'b1; d.reg_we = 1'b1;
            end
            OP_JAL: begin
                d.rs1 = '0;
                d.imm = {{(XLEN-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                d.src_imm = 1'b1; d.src_pc = 1'b1; d.jump = 1'b1; d.reg_we = 1'b1;
            end
            OP_JALR: begin
                d.imm = {{(XLEN-12){ins[31]}}, ins[31:20]};
                d.src_imm = 1'b1; d.jump = 1'b1; d.reg_we = 1'b1;
                bad = bad | (f3 != 3'b000);
            end
            OP_BRANCH: begin
                d.imm = {{(XLEN-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                d.src_pc = 1'b1; d.branch = 1'b1;
                case (f3)
                    3'b000, 3'b001: d.alu_op = ALU_SUB;
                    3'b100, 3'b101: d.alu_op = ALU_SLT;
                    3'b110, 3'b111: d.alu_op = ALU_SLTU;
                    default:        bad = 1'b1;
                endcase
            end
            OP_LOAD: begin
                d.imm = {{(XLEN-12){ins[31]}}, ins[31:20]};
                d.src_imm = 1'b1; d.mem_rd = 1'b1; d.reg_we = 1'b1;
                bad = bad | (f3 == 3'b111);
            end
            OP_STORE: begin
                d.imm = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
                d.src_imm = 1'b1; d.mem_wr = 1'b1;
                bad = bad | f3[2];
            end
            OP_IMM: begin
                // instr[30] only selects SRA here; ADDI never becomes SUB
                d.imm = {{(XLEN-12){ins[31]}}, ins[31:20]};
                d.src_imm = 1'b1; d.reg_we = 1'b1;
                d.alu_op = alu_from_f3(f3, ins[30] & (f3 == 3'b101));
                if (f3 == 3'b001)
                    bad = bad | (ins[31:26] != 6'b000000);
                if (f3 == 3'b101)
                    bad = bad | ((ins[31:26] != 6'b000000) && (ins[31:26] != 6'b010000));
            end
            OP_REG: begin
                d.reg_we = 1'b1;
                d.alu_op = alu_from_f3(f3, ins[30]);
                bad = bad | !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            OP_SYSTEM: begin
                d.imm = {{(XLEN-12){ins[31]}}, ins[31:20]};
                d.src_imm = 1'b1; d.system = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        d.illegal = bad;
        d.reg_we  = d.reg_we & (d.rd != 5'd0) & !bad;
        d.mem_rd  = d.mem_rd & !bad;
        d.mem_wr  = d.mem_wr & !bad;
        d.branch  = d.branch & !bad;
        d.jump    = d.jump & !bad;
        return d;
    endfunction

    dec_t out_q, out_d, skid_q, skid_d;
    logic out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
    logic accept, consume;

    assign if_ready_o = !skid_vld_q;
    assign accept     = if_valid_i & if_ready_o;
    assign consume    = out_vld_q & id_ready_i;

    always_comb begin
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (flush_i) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!out_vld_q || consume) begin
            if (skid_vld_q) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                out_d     = decode(if_pc_i, if_instr_i);
                out_vld_d = 1'b1;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (accept) begin
            skid_d     = decode(if_pc_i, if_instr_i);
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q      <= '0;
            skid_q     <= '0;
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            skid_q     <= skid_d;
            out_vld_q  <= out_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign id_valid_o   = out_vld_q;
    assign id_pc_o      = out_q.pc;
    assign id_rs1_o     = out_q.rs1;
    assign id_rs2_o     = out_q.rs2;
    assign id_rd_o      = out_q.rd;
    assign id_imm_o     = out_q.imm;
    assign id_alu_op_o  = out_q.alu_op;
    assign id_src_imm_o = out_q.src_imm;
    assign id_src_pc_o  = out_q.src_pc;
    assign id_reg_we_o  = out_q.reg_we;
    assign id_mem_rd_o  = out_q.mem_rd;
    assign id_mem_wr_o  = out_q.mem_wr;
    assign id_branch_o  = out_q.branch;
    assign id_jump_o    = out_q.jump;
    assign id_system_o  = out_q.system;
    assign id_funct3_o  = out_q.funct3;
    assign id_illegal_o = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage: decode fields, skid buffering, flush and async reset.
module tb_decode_stage;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SRA = 4'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        if_valid_i = 1'b0;
    logic        if_ready_o;
    logic [63:0] if_pc_i = '0;
    logic [31:0] if_instr_i = '0;
    logic        id_valid_o;
    logic        id_ready_i = 1'b1;
    logic [63:0] id_pc_o, id_imm_o;
    logic [4:0]  id_rs1_o, id_rs2_o, id_rd_o;
    logic [3:0]  id_alu_op_o;
    logic        id_src_imm_o, id_src_pc_o, id_reg_we_o, id_mem_rd_o, id_mem_wr_o;
    logic        id_branch_o, id_jump_o, id_system_o, id_illegal_o;
    logic [2:0]  id_funct3_o;

    int n_cmp = 0;
    int n_fail = 0;

    decode_stage #(.XLEN(64), .ILEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
        .if_pc_i(if_pc_i), .if_instr_i(if_instr_i),
        .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
        .id_pc_o(id_pc_o), .id_rs1_o(id_rs1_o), .id_rs2_o(id_rs2_o), .id_rd_o(id_rd_o),
        .id_imm_o(id_imm_o), .id_alu_op_o(id_alu_op_o),
        .id_src_imm_o(id_src_imm_o), .id_src_pc_o(id_src_pc_o), .id_reg_we_o(id_reg_we_o),
        .id_mem_rd_o(id_mem_rd_o), .id_mem_wr_o(id_mem_wr_o),
        .id_branch_o(id_branch_o), .id_jump_o(id_jump_o), .id_system_o(id_system_o),
        .id_funct3_o(id_funct3_o), .id_illegal_o(id_illegal_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction for a single cycle; outputs are inspected right after the edge.
    task automatic send1(input logic [63:0] pc, input logic [31:0] ins);
        if_pc_i    = pc;
        if_instr_i = ins;
        if_valid_i = 1'b1;
        step();
        if_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_cmp++; if (id_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", id_valid_o); end
        n_cmp++; if (if_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", if_ready_o); end
        n_cmp++; if (id_imm_o !== 64'd0) begin n_fail++; $display("FAIL rst_imm: got %h want 0", id_imm_o); end
        n_cmp++; if (id_alu_op_o !== ALU_ADD) begin n_fail++; $display("FAIL rst_alu: got %0d want %0d", id_alu_op_o, ALU_ADD); end
        n_cmp++; if (id_pc_o !== 64'd0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", id_pc_o); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_addi();
        send1(64'h1000, 32'hFFF00093);
        n_cmp++; if (id_valid_o !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %b want 1", id_valid_o); end
        n_cmp++; if (id_pc_o !== 64'h1000) begin n_fail++; $display("FAIL addi_pc: got %h want 1000", id_pc_o); end
        n_cmp++; if (id_rd_o !== 5'd1 || id_rs1_o !== 5'd0) begin n_fail++; $display("FAIL addi_regs: got rd=%0d rs1=%0d want rd=1 rs1=0", id_rd_o, id_rs1_o); end
        n_cmp++; if (id_imm_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL addi_imm: got %h want ffffffffffffffff", id_imm_o); end
        n_cmp++; if (id_alu_op_o !== ALU_ADD) begin n_fail++; $display("FAIL addi_alu: got %0d want %0d", id_alu_op_o, ALU_ADD); end
        n_cmp++; if ({id_src_imm_o, id_reg_we_o, id_illegal_o} !== 3'b110) begin n_fail++; $display("FAIL addi_flags: got src_imm/we/ill=%b want 110", {id_src_imm_o, id_reg_we_o, id_illegal_o}); end
        step();
        n_cmp++; if (id_valid_o !== 1'b0) begin n_fail++; $display("FAIL addi_drain: got %b want 0", id_valid_o); end
    endtask

    task automatic test_sub_illegal();
        send1(64'h1004, 32'h402081B3);
        n_cmp++; if (id_alu_op_o !== ALU_SUB) begin n_fail++; $display("FAIL sub_alu: got %0d want %0d", id_alu_op_o, ALU_SUB); end
        n_cmp++; if ({id_rs1_o, id_rs2_o, id_rd_o} !== {5'd1, 5'd2, 5'd3}) begin n_fail++; $display("FAIL sub_regs: got %0d/%0d/%0d want 1/2/3", id_rs1_o, id_rs2_o, id_rd_o); end
        n_cmp++; if ({id_src_imm_o, id_reg_we_o, id_imm_o} !== {1'b0, 1'b1, 64'd0}) begin n_fail++; $display("FAIL sub_flags: got src_imm=%b we=%b imm=%h want 0 1 0", id_src_imm_o, id_reg_we_o, id_imm_o); end
        send1(64'h1008, 32'h00000000);
        n_cmp++; if ({id_valid_o, id_illegal_o, id_reg_we_o} !== 3'b110) begin n_fail++; $display("FAIL zero_illegal: got vld/ill/we=%b want 110", {id_valid_o, id_illegal_o, id_reg_we_o}); end
        send1(64'h100C, 32'h80005093);
        n_cmp++; if ({id_illegal_o, id_reg_we_o} !== 2'b10) begin n_fail++; $display("FAIL shift_f6: got ill/we=%b want 10", {id_illegal_o, id_reg_we_o}); end
        send1(64'h1010, 32'h43F0D093);
        n_cmp++; if ({id_illegal_o, id_alu_op_o} !== {1'b0, ALU_SRA}) begin n_fail++; $display("FAIL srai63: got ill=%b alu=%0d want 0 %0d", id_illegal_o, id_alu_op_o, ALU_SRA); end
        step();
    endtask

    task automatic test_branch();
        send1(64'h2000, 32'hFE000EE3);
        n_cmp++; if (id_imm_o !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL beq_imm: got %h want fffffffffffffffc", id_imm_o); end
        n_cmp++; if (id_alu_op_o !== ALU_SUB) begin n_fail++; $display("FAIL beq_alu: got %0d want %0d", id_alu_op_o, ALU_SUB); end
        n_cmp++; if ({id_branch_o, id_src_pc_o, id_reg_we_o, id_jump_o} !== 4'b1100) begin n_fail++; $display("FAIL beq_flags: got br/pc/we/j=%b want 1100", {id_branch_o, id_src_pc_o, id_reg_we_o, id_jump_o}); end
        step();
    endtask

    task automatic test_other_formats();
        send1(64'h3000, 32'h123452B7);
        n_cmp++; if ({id_rs1_o, id_rd_o, id_imm_o} !== {5'd0, 5'd5, 64'h12345000}) begin n_fail++; $display("FAIL lui: got rs1=%0d rd=%0d imm=%h want 0 5 12345000", id_rs1_o, id_rd_o, id_imm_o); end
        send1(64'h3004, 32'h800000B7);
        n_cmp++; if (id_imm_o !== 64'hFFFF_FFFF_8000_0000) begin n_fail++; $display("FAIL lui_sext: got %h want ffffffff80000000", id_imm_o); end
        send1(64'h3008, 32'h008000EF);
        n_cmp++; if ({id_imm_o, id_jump_o, id_src_pc_o, id_reg_we_o} !== {64'd8, 3'b111}) begin n_fail++; $display("FAIL jal: got imm=%h j/pc/we=%b want 8 111", id_imm_o, {id_jump_o, id_src_pc_o, id_reg_we_o}); end
        send1(64'h300C, 32'h0020A423);
        n_cmp++; if ({id_imm_o, id_mem_wr_o, id_reg_we_o, id_funct3_o} !== {64'd8, 2'b10, 3'b010}) begin n_fail++; $display("FAIL sw: got imm=%h wr=%b we=%b f3=%0d want 8 1 0 2", id_imm_o, id_mem_wr_o, id_reg_we_o, id_funct3_o); end
        step();
    endtask

    task automatic test_back_to_back();
        id_ready_i = 1'b0;
        send1(64'h100, 32'h00100093);
        send1(64'h104, 32'h00200113);
        if_pc_i = 64'h108; if_instr_i = 32'h00300193; if_valid_i = 1'b1;
        step();
        n_cmp++; if ({id_valid_o, if_ready_o, id_pc_o} !== {2'b10, 64'h100}) begin n_fail++; $display("FAIL b2b_full: got vld=%b rdy=%b pc=%h want 1 0 100", id_valid_o, if_ready_o, id_pc_o); end
        id_ready_i = 1'b1;
        step();
        n_cmp++; if ({id_valid_o, id_pc_o, id_rd_o} !== {1'b1, 64'h104, 5'd2}) begin n_fail++; $display("FAIL b2b_second: got vld=%b pc=%h rd=%0d want 1 104 2", id_valid_o, id_pc_o, id_rd_o); end
        step();
        if_valid_i = 1'b0;
        n_cmp++; if ({id_valid_o, id_pc_o, id_rd_o} !== {1'b1, 64'h108, 5'd3}) begin n_fail++; $display("FAIL b2b_third: got vld=%b pc=%h rd=%0d want 1 108 3", id_valid_o, id_pc_o, id_rd_o); end
        step();
        n_cmp++; if (id_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_nodup: got %b want 0", id_valid_o); end
    endtask

    task automatic test_flush();
        id_ready_i = 1'b0;
        send1(64'h200, 32'h00100093);
        send1(64'h204, 32'h00200113);
        if_pc_i = 64'h208; if_instr_i = 32'h00300193; if_valid_i = 1'b1;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        if_valid_i = 1'b0;
        n_cmp++; if ({id_valid_o, if_ready_o} !== 2'b01) begin n_fail++; $display("FAIL flush_full: got vld=%b rdy=%b want 0 1", id_valid_o, if_ready_o); end
        id_ready_i = 1'b1;
        step();
        step();
        n_cmp++; if (id_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_quiet: got %b want 0", id_valid_o); end
        if_pc_i = 64'h20C; if_instr_i = 32'h00400213; if_valid_i = 1'b1; flush_i = 1'b1;
        step();
        flush_i = 1'b0; if_valid_i = 1'b0;
        n_cmp++; if (id_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_accept: got %b want 0", id_valid_o); end
    endtask

    task automatic test_async_reset();
        id_ready_i = 1'b0;
        send1(64'h300, 32'h00100093);
        send1(64'h304, 32'h00200113);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({id_valid_o, if_ready_o, id_pc_o} !== {2'b01, 64'd0}) begin n_fail++; $display("FAIL async_rst: got vld=%b rdy=%b pc=%h want 0 1 0", id_valid_o, if_ready_o, id_pc_o); end
        step();
        rst_n = 1'b1;
        id_ready_i = 1'b1;
        step();
        n_cmp++; if (id_valid_o !== 1'b0) begin n_fail++; $display("FAIL async_lost: got %b want 0", id_valid_o); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_sub_illegal();
        test_branch();
        test_other_formats();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
